gol_run_ctrl: RTL and testbench
===============================

Name: gol_run_ctrl

Overview:
Run controller for the 8x8 Game of Life board. It owns the 64-bit board register and drives the pattern loader's pattern_id. It sequences pattern loading, then advances the board one generation at a time from an external combinational next-state evaluator, in free-run (timed), single-step or paused modes. It halts automatically when the board reaches a still life.

Parameters:
TICK_DIV, 50_000_000, clk cycles between generations in RUN; legal range >= 2
GEN_W, 16, width of the generation counter

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
load_req  in  1  one-cycle pulse: load pattern load_id
load_id  in  4  pattern selector, sampled with load_req
run_en  in  1  level: free-run when high
step  in  1  one-cycle pulse: advance exactly one generation while paused
pattern_mat_in  in  64 [0:63]  registered output of the pattern loader
next_mat_in  in  64 [0:63]  next generation of board, from the combinational evaluator
pattern_id  out  4  to the pattern loader
board  out  64 [0:63]  current generation; row-major, bit 0 = top-left
gen_count  out  GEN_W  generations since the last load
busy  out  1  load in progress
running  out  1  state == RUN
stable  out  1  state == HALTED
empty  out  1  board == 0

Behaviour:
- Reset (rst high at a clk edge): state IDLE; board=0, pattern_id=0, gen_count=0, tick counter=0; busy=running=stable=0; empty=1. Reset mid-load or mid-run aborts immediately. No partial board update.
- States: IDLE, LOAD_WAIT, LOAD_CAP, PAUSED, RUN, HALTED.
- Priority in every non-load state: load_req > step > run_en.
- load_req sampled at edge N in IDLE/PAUSED/RUN/HALTED:
  - pattern_id <= load_id; state LOAD_WAIT.
  - Edge N+1: LOAD_CAP (the loader registers its output at this edge).
  - Edge N+2: board <= pattern_mat_in, gen_count <= 0, tick <= 0, state PAUSED.
  - busy is high during LOAD_WAIT and LOAD_CAP (exactly 2 cycles).
  - load_req, step and run_en are ignored while busy.
  - pattern_id holds its value after the load.
- IDLE: step and run_en are ignored; only load_req leaves IDLE.
- PAUSED:
  - step=1 → one advance at that edge; stays PAUSED.
  - Otherwise run_en=1 → RUN, tick <= 0.
- RUN:
  - tick counts 0..TICK_DIV-1.
  - At an edge with tick == TICK_DIV-1: advance, tick <= 0. First advance occurs TICK_DIV cycles after entering RUN.
  - run_en=0 → PAUSED, tick <= 0, no advance that edge.
  - step is ignored in RUN.
- Advance:
  - If next_mat_in == board: board unchanged, gen_count unchanged, state HALTED.
  - Else: board <= next_mat_in; gen_count <= gen_count+1, saturating at all-ones.
- HALTED: board frozen; run_en and step are ignored; only load_req leaves (via the load sequence). An all-zero board halts on its first advance attempt.
- running, stable and busy are decodes of the registered state. empty is a decode of the registered board. All outputs are registered or derived from registers only; no combinational path from inputs.
- Toroidal or edge rules belong to the evaluator; this block never inspects neighbourhoods.

Test Plan:
- Reset during LOAD_CAP (load_req id 7, then rst two cycles later) → board=0, state IDLE, busy=0, empty=1, pattern_id=0.
- load_req id 7, loader modelled with a 1-cycle register → busy high exactly 2 cycles; board=64'hE000_0000_0000_0000 after edge N+2; gen_count=0; running=0.
- After the id-7 load, step pulse → board equals the bench evaluator's output for the blinker, gen_count=1, still PAUSED. A second step → board=64'hE000_0000_0000_0000, gen_count=2.
- TICK_DIV=4, id 7 loaded, run_en=1 held → board advances on every 4th edge after entering RUN; gen_count 1,2,3 at edges 4,8,12. Dropping run_en at edge 6 → PAUSED, no advance at 8.
- Load id 4 (tub, still life), step → stable=1, board unchanged, gen_count=0. Further step/run_en have no effect. A load_req of id 2 exits to PAUSED with stable=0.
- Load id 0 (loader default → zero board) → empty=1. run_en=1 → HALTED on the first tick with gen_count=0. load_req asserted on the same edge as step in PAUSED → load wins, no advance.

Source files
------------

// File: rtl/gol_run_ctrl_if.sv
// Host-side signal bundle for the Game of Life run controller.
// The controller uses the slave modport; the host/loader/evaluator side uses master.
interface gol_run_ctrl_if #(
    parameter int GEN_W = 16
);
    logic             load_req;
    logic [3:0]       load_id;
    logic             run_en;
    logic             step;
    logic [0:63]      pattern_mat_in;
    logic [0:63]      next_mat_in;
    logic [3:0]       pattern_id;
    logic [0:63]      board;
    logic [GEN_W-1:0] gen_count;
    logic             busy;
    logic             running;
    logic             stable;
    logic             empty;

    modport master (
        output load_req, load_id, run_en, step, pattern_mat_in, next_mat_in,
        input  pattern_id, board, gen_count, busy, running, stable, empty
    );

    modport slave (
        input  load_req, load_id, run_en, step, pattern_mat_in, next_mat_in,
        output pattern_id, board, gen_count, busy, running, stable, empty
    );
endinterface

// File: rtl/gol_run_ctrl.sv
// Run controller for the 8x8 Game of Life board: sequences pattern loads and
// advances the board in timed, single-step or paused modes, halting on a still life.
module gol_run_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int GEN_W    = 16
) (
    input logic           clk,
    input logic           rst,
    gol_run_ctrl_if.slave bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WAIT,
        LOAD_CAP,
        PAUSED,
        RUN,
        HALTED
    } state_e;

    state_e           state_q;
    logic [0:63]      board_q;
    logic [3:0]       pid_q;
    logic [GEN_W-1:0] gen_q;
    logic [GEN_W-1:0] gen_d;
    logic [TW-1:0]    tick_q;
    logic             still_d;
    logic             can_load_d;

    always_comb begin
        still_d    = (bus.next_mat_in == board_q);
        gen_d      = (&gen_q) ? gen_q : gen_q + 1'b1;
        can_load_d = (state_q == IDLE) || (state_q == PAUSED) ||
                     (state_q == RUN)  || (state_q == HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            board_q <= '0;
            pid_q   <= '0;
            gen_q   <= '0;
            tick_q  <= '0;
        end else if (can_load_d && bus.load_req) begin
            pid_q   <= bus.load_id;
            state_q <= LOAD_WAIT;
        end else begin
            case (state_q)
                LOAD_WAIT: state_q <= LOAD_CAP;
                // Loader output became valid at the previous edge; capture it now.
                LOAD_CAP: begin
                    board_q <= bus.pattern_mat_in;
                    gen_q   <= '0;
                    tick_q  <= '0;
                    state_q <= PAUSED;
                end
                PAUSED: begin
                    if (bus.step) begin
                        if (still_d) begin
                            state_q <= HALTED;
                        end else begin
                            board_q <= bus.next_mat_in;
                            gen_q   <= gen_d;
                        end
                    end else if (bus.run_en) begin
                        tick_q  <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.run_en) begin
                        tick_q  <= '0;
                        state_q <= PAUSED;
                    end else if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        if (still_d) begin
                            state_q <= HALTED;
                        end else begin
                            board_q <= bus.next_mat_in;
                            gen_q   <= gen_d;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pattern_id = pid_q;
    assign bus.board      = board_q;
    assign bus.gen_count  = gen_q;
    assign bus.busy       = (state_q == LOAD_WAIT) || (state_q == LOAD_CAP);
    assign bus.running    = (state_q == RUN);
    assign bus.stable     = (state_q == HALTED);
    assign bus.empty      = (board_q == '0);
endmodule

// File: tb/tb_gol_run_ctrl.sv
// Scoreboard bench for gol_run_ctrl with a registered pattern loader and a toroidal
// Life evaluator modelled alongside the DUT.
module tb_gol_run_ctrl;
    localparam int TICK_DIV = 4;
    localparam int GEN_W    = 16;

    localparam int K_BOARD = 0, K_GEN = 1, K_BUSY = 2, K_RUN = 3,
                   K_STAB = 4, K_EMPTY = 5, K_PID = 6;

    localparam logic [63:0] BLINK_H = 64'hE000_0000_0000_0000;
    localparam logic [63:0] TUB     = 64'h40A0_4000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gol_run_ctrl_if #(.GEN_W(GEN_W)) bus();

    gol_run_ctrl #(.TICK_DIV(TICK_DIV), .GEN_W(GEN_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          kind;
        logic [63:0] val;
        string       tag;
    } sb_t;

    sb_t sbq[$];
    int  n_total = 0;
    int  n_bad   = 0;

    function automatic logic [0:63] rom(input logic [3:0] id);
        logic [0:63] m;
        m = '0;
        case (id)
            4'd7: begin m[0] = 1'b1; m[1] = 1'b1; m[2] = 1'b1; end
            4'd4: begin m[1] = 1'b1; m[8] = 1'b1; m[10] = 1'b1; m[17] = 1'b1; end
            4'd2: begin m[1] = 1'b1; m[10] = 1'b1; m[16] = 1'b1; m[17] = 1'b1; m[18] = 1'b1; end
            default: ;
        endcase
        return m;
    endfunction

    function automatic logic [0:63] life_next(input logic [0:63] b);
        logic [0:63] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0))
                            cnt += int'(b[((r + dr + 8) % 8) * 8 + ((c + dc + 8) % 8)]);
                    end
                end
                n[r*8+c] = (cnt == 3) || (b[r*8+c] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Loader: one-cycle registered ROM; evaluator: combinational.
    always @(posedge clk) bus.pattern_mat_in <= rom(bus.pattern_id);
    assign bus.next_mat_in = life_next(bus.board);

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int kind);
        logic [63:0] v;
        case (kind)
            K_BOARD: v = bus.board;
            K_GEN:   v = 64'(bus.gen_count);
            K_BUSY:  v = 64'(bus.busy);
            K_RUN:   v = 64'(bus.running);
            K_STAB:  v = 64'(bus.stable);
            K_EMPTY: v = 64'(bus.empty);
            default: v = 64'(bus.pattern_id);
        endcase
        return v;
    endfunction

    task automatic push(input int kind, input logic [63:0] v, input string tag);
        sb_t e;
        e.kind = kind;
        e.val  = v;
        e.tag  = tag;
        sbq.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_val(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] id, input logic [63:0] eb, input string tag);
        bus.load_id  = id;
        bus.load_req = 1'b1;
        push(K_BUSY, 64'd1, {tag, "_busy1"});
        push(K_PID, {60'd0, id}, {tag, "_pid"});
        step_clk();
        drain();
        bus.load_req = 1'b0;
        push(K_BUSY, 64'd1, {tag, "_busy2"});
        step_clk();
        drain();
        push(K_BUSY, 64'd0, {tag, "_busy3"});
        push(K_BOARD, eb, {tag, "_board"});
        push(K_GEN, 64'd0, {tag, "_gen"});
        push(K_RUN, 64'd0, {tag, "_run"});
        push(K_STAB, 64'd0, {tag, "_stab"});
        push(K_EMPTY, {63'd0, eb == 64'd0}, {tag, "_empty"});
        step_clk();
        drain();
    endtask

    initial begin
        logic [63:0] eb;
        rst          = 1'b1;
        bus.load_req = 1'b0;
        bus.load_id  = 4'd0;
        bus.run_en   = 1'b0;
        bus.step     = 1'b0;
        step_clk();
        step_clk();
        rst = 1'b0;
        push(K_BOARD, 64'd0, "rst_board");
        push(K_GEN, 64'd0, "rst_gen");
        push(K_BUSY, 64'd0, "rst_busy");
        push(K_RUN, 64'd0, "rst_run");
        push(K_STAB, 64'd0, "rst_stab");
        push(K_EMPTY, 64'd1, "rst_empty");
        push(K_PID, 64'd0, "rst_pid");
        drain();

        // IDLE ignores step and run_en
        bus.run_en = 1'b1;
        bus.step   = 1'b1;
        step_clk();
        step_clk();
        push(K_RUN, 64'd0, "idle_run");
        push(K_GEN, 64'd0, "idle_gen");
        push(K_BOARD, 64'd0, "idle_board");
        drain();
        bus.run_en = 1'b0;
        bus.step   = 1'b0;

        // Reset during LOAD_CAP aborts the load
        bus.load_id  = 4'd7;
        bus.load_req = 1'b1;
        step_clk();
        bus.load_req = 1'b0;
        step_clk();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        push(K_BOARD, 64'd0, "abort_board");
        push(K_BUSY, 64'd0, "abort_busy");
        push(K_EMPTY, 64'd1, "abort_empty");
        push(K_PID, 64'd0, "abort_pid");
        push(K_RUN, 64'd0, "abort_run");
        drain();

        // Blinker load and two single steps
        do_load(4'd7, BLINK_H, "ld7");
        eb = life_next(BLINK_H);
        bus.step = 1'b1;
        push(K_BOARD, eb, "step1_board");
        push(K_GEN, 64'd1, "step1_gen");
        push(K_RUN, 64'd0, "step1_run");
        push(K_STAB, 64'd0, "step1_stab");
        step_clk();
        drain();
        push(K_BOARD, BLINK_H, "step2_board");
        push(K_GEN, 64'd2, "step2_gen");
        step_clk();
        drain();
        bus.step = 1'b0;

        // Timed run: advance every TICK_DIV edges after entering RUN
        do_load(4'd7, BLINK_H, "ld7r");
        bus.run_en = 1'b1;
        push(K_RUN, 64'd1, "run_enter");
        step_clk();
        drain();
        eb = BLINK_H;
        for (int k = 1; k <= 12; k++) begin
            if (k % TICK_DIV == 0) eb = life_next(eb);
            push(K_BOARD, eb, $sformatf("run_board_%0d", k));
            push(K_GEN, 64'(k / TICK_DIV), $sformatf("run_gen_%0d", k));
            push(K_RUN, 64'd1, $sformatf("run_run_%0d", k));
            step_clk();
            drain();
        end
        bus.run_en = 1'b0;
        step_clk();

        // Dropping run_en at edge 6 pauses with no advance at edge 8
        do_load(4'd7, BLINK_H, "ld7p");
        bus.run_en = 1'b1;
        step_clk();
        for (int k = 1; k <= 8; k++) begin
            if (k == 6) bus.run_en = 1'b0;
            push(K_GEN, (k >= 4) ? 64'd1 : 64'd0, $sformatf("pause_gen_%0d", k));
            push(K_RUN, (k < 6) ? 64'd1 : 64'd0, $sformatf("pause_run_%0d", k));
            step_clk();
            drain();
        end

        // Still life halts; HALTED ignores step and run_en
        do_load(4'd4, TUB, "ld4");
        bus.step = 1'b1;
        push(K_STAB, 64'd1, "tub_stab");
        push(K_BOARD, TUB, "tub_board");
        push(K_GEN, 64'd0, "tub_gen");
        step_clk();
        drain();
        bus.run_en = 1'b1;
        repeat (6) step_clk();
        bus.step   = 1'b0;
        bus.run_en = 1'b0;
        push(K_STAB, 64'd1, "halt_stab");
        push(K_RUN, 64'd0, "halt_run");
        push(K_BOARD, TUB, "halt_board");
        push(K_GEN, 64'd0, "halt_gen");
        drain();
        do_load(4'd2, rom(4'd2), "ld2");

        // Empty board halts on its first tick
        do_load(4'd0, 64'd0, "ld0");
        bus.run_en = 1'b1;
        push(K_RUN, 64'd1, "empty_enter");
        step_clk();
        drain();
        repeat (TICK_DIV - 1) step_clk();
        push(K_RUN, 64'd1, "empty_pre_run");
        push(K_STAB, 64'd0, "empty_pre_stab");
        drain();
        push(K_STAB, 64'd1, "empty_stab");
        push(K_RUN, 64'd0, "empty_run");
        push(K_GEN, 64'd0, "empty_gen");
        push(K_EMPTY, 64'd1, "empty_flag");
        step_clk();
        drain();
        bus.run_en = 1'b0;

        // load_req beats step on the same edge
        do_load(4'd7, BLINK_H, "ld7c");
        bus.step     = 1'b1;
        bus.load_req = 1'b1;
        bus.load_id  = 4'd4;
        push(K_BUSY, 64'd1, "prio_busy");
        push(K_BOARD, BLINK_H, "prio_board");
        push(K_GEN, 64'd0, "prio_gen");
        push(K_PID, 64'd4, "prio_pid");
        step_clk();
        drain();
        bus.step     = 1'b0;
        bus.load_req = 1'b0;
        step_clk();
        push(K_BOARD, TUB, "prio_final_board");
        push(K_BUSY, 64'd0, "prio_final_busy");
        push(K_GEN, 64'd0, "prio_final_gen");
        step_clk();
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
